// File: rtl/gpu_pkg.sv
// Shared constants and types for the SPI mode controller.
package gpu_pkg;

  // Default colour register width (RGB222)
  localparam int unsigned COLOR_W_DEF = 6;

  // Command opcodes carried in byte[7:6]
  localparam logic [1:0] OP_MODE   = 2'b00;
  localparam logic [1:0] OP_FG     = 2'b01;
  localparam logic [1:0] OP_BG     = 2'b10;
  localparam logic [1:0] OP_COMMIT = 2'b11;

  // Reset values; colours are given as a fill bit so they scale with COLOR_W
  localparam logic [1:0] MODE_RESET    = 2'b00;
  localparam logic       FG_RESET_FILL = 1'b1;
  localparam logic       BG_RESET_FILL = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDecode
  } spi_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  // Shift the input through the flop chain; reset to the idle level
  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= {STAGES{RESET_VAL}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/spi_mode_ctrl.sv
// SPI mode-0 slave receiving mode/colour commands into shadow registers,
// committed to the active outputs on frame_start or a commit opcode.
// Optional feature: define SPI_MISO_READBACK_EN to echo the previous byte on spi_miso.
module spi_mode_ctrl
  import gpu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COLOR_W     = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spi_sck,
  input  logic               spi_mosi,
  input  logic               spi_cs_n,
  output logic               spi_miso,
  input  logic               frame_start,
  output logic [1:0]         mode_sel,
  output logic [COLOR_W-1:0] fg_color,
  output logic [COLOR_W-1:0] bg_color,
  output logic               cmd_strobe
);

  localparam logic [COLOR_W-1:0] FgReset = {COLOR_W{FG_RESET_FILL}};
  localparam logic [COLOR_W-1:0] BgReset = {COLOR_W{BG_RESET_FILL}};

  logic sck_s, mosi_s, cs_n_s;
  logic sck_prev_q;
  logic sck_rise;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .reset (reset),
    .d     (spi_sck),
    .q     (sck_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .d     (spi_mosi),
    .q     (mosi_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .d     (spi_cs_n),
    .q     (cs_n_s)
  );

  assign sck_rise = sck_s & ~sck_prev_q;

  spi_state_e         state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [1:0]         sh_mode_q, sh_mode_d;
  logic [COLOR_W-1:0] sh_fg_q, sh_fg_d;
  logic [COLOR_W-1:0] sh_bg_q, sh_bg_d;
  logic [1:0]         mode_q;
  logic [COLOR_W-1:0] fg_q, bg_q;
  logic               commit;

  // Receive FSM, command decode into shadow registers, commit request
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sh_mode_d = sh_mode_q;
    sh_fg_d   = sh_fg_q;
    sh_bg_d   = sh_bg_q;
    commit    = frame_start;
    unique case (state_q)
      StIdle: begin
        bit_cnt_d = 3'd0;
        if (!cs_n_s) state_d = StShift;
      end
      StShift: begin
        if (cs_n_s) begin
          // Partial byte is dropped; shadows untouched
          state_d   = StIdle;
          bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
          shift_d   = {shift_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = cs_n_s ? StIdle : StShift;
        unique case (shift_q[7:6])
          OP_MODE:   sh_mode_d = shift_q[1:0];
          OP_FG:     sh_fg_d   = COLOR_W'(shift_q[5:0]);
          OP_BG:     sh_bg_d   = COLOR_W'(shift_q[5:0]);
          OP_COMMIT: commit    = 1'b1;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  // State, shadow and active registers; commit takes the post-write shadow values
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      sck_prev_q <= 1'b0;
      sh_mode_q  <= MODE_RESET;
      sh_fg_q    <= FgReset;
      sh_bg_q    <= BgReset;
      mode_q     <= MODE_RESET;
      fg_q       <= FgReset;
      bg_q       <= BgReset;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sck_prev_q <= sck_s;
      sh_mode_q  <= sh_mode_d;
      sh_fg_q    <= sh_fg_d;
      sh_bg_q    <= sh_bg_d;
      if (commit) begin
        mode_q <= sh_mode_d;
        fg_q   <= sh_fg_d;
        bg_q   <= sh_bg_d;
      end
    end
  end

  assign mode_sel   = mode_q;
  assign fg_color   = fg_q;
  assign bg_color   = bg_q;
  assign cmd_strobe = (state_q == StDecode);

`ifdef SPI_MISO_READBACK_EN
  logic       sck_fall;
  logic [7:0] last_q, tx_q;

  assign sck_fall = ~sck_s & sck_prev_q;

  // Readback shifter: load on CS fall or after a byte, shift on SCK falls within a byte.
  // The fall after the 8th rise sees bit_cnt_q == 0 and is skipped so a back-to-back
  // byte keeps its MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 8'h00;
      tx_q   <= 8'h00;
    end else if (state_q == StIdle && !cs_n_s) begin
      tx_q <= last_q;
    end else if (state_q == StDecode) begin
      last_q <= shift_q;
      tx_q   <= shift_q;
    end else if (state_q == StShift && sck_fall && bit_cnt_q != 3'd0) begin
      tx_q <= {tx_q[6:0], 1'b0};
    end
  end

  assign spi_miso = tx_q[7];
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mode_ctrl.sv
// Directed self-checking bench for spi_mode_ctrl (SCK at clk/8).
module tb_spi_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_miso;
  logic       frame_start;
  logic [1:0] mode_sel;
  logic [5:0] fg_color;
  logic [5:0] bg_color;
  logic       cmd_strobe;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  spi_mode_ctrl #(.SYNC_STAGES(2), .COLOR_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .frame_start (frame_start),
    .mode_sel    (mode_sel),
    .fg_color    (fg_color),
    .bg_color    (bg_color),
    .cmd_strobe  (cmd_strobe)
  );

  always @(posedge clk) begin
    if (reset) strobe_cnt = 0;
    else if (cmd_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
  end

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
  endtask

  // Send the top n bits of b MSB first; MISO is captured just before each rising SCK
  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      spi_mosi = b[i];
      repeat (4) @(negedge clk);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  // Final bit with per-cycle observation: strb[k] is cmd_strobe after the (k+1)th posedge
  // following the SCK rise; frame_start optionally driven during the decode cycle
  task automatic last_bit(input logic b0, input logic fs, output logic [3:0] strb,
                          output logic [1:0] mode_p3, output logic [5:0] fg_p3);
    spi_mosi = b0;
    repeat (4) @(negedge clk);
    spi_sck = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 strb[k] = cmd_strobe;
    end
    mode_p3 = mode_sel;
    fg_p3   = fg_color;
    @(negedge clk);
    frame_start = fs;
    @(posedge clk);
    #1 strb[3] = cmd_strobe;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; frame_start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (mode_sel !== 2'b00) begin errors++; $display("FAIL rst_mode got %b want 00", mode_sel); end
    checks++; if (fg_color !== 6'h3f) begin errors++; $display("FAIL rst_fg got %h want 3f", fg_color); end
    checks++; if (bg_color !== 6'h00) begin errors++; $display("FAIL rst_bg got %h want 00", bg_color); end
    checks++; if (cmd_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b want 0", cmd_strobe); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL rst_miso got %b want 0", spi_miso); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (strobe_cnt != 0) begin errors++; $display("FAIL idle_strobe got %0d want 0", strobe_cnt); end
  endtask

  task automatic test_mode_write();
    int s0;
    logic [7:0] rx;
    s0 = strobe_cnt;
    cs_low();
    send_bits(8'h02, 8, rx);
    cs_high();
    checks++; if (strobe_cnt != s0 + 1) begin errors++; $display("FAIL mode_strobes got %0d want %0d", strobe_cnt - s0, 1); end
    checks++; if (mode_sel !== 2'b00) begin errors++; $display("FAIL mode_pre_commit got %b want 00", mode_sel); end
    pulse_frame();
    checks++; if (mode_sel !== 2'b10) begin errors++; $display("FAIL mode_post_commit got %b want 10", mode_sel); end
    checks++; if (fg_color !== 6'h3f) begin errors++; $display("FAIL mode_fg_hold got %h want 3f", fg_color); end
    checks++; if (bg_color !== 6'h00) begin errors++; $display("FAIL mode_bg_hold got %h want 00", bg_color); end
  endtask

  task automatic test_fg_commit();
    int s0;
    logic [7:0] rx;
    logic [3:0] strb;
    logic [1:0] mp3;
    logic [5:0] fp3;
    s0 = strobe_cnt;
    cs_low();
    send_bits(8'h55, 8, rx);
    checks++; if (strobe_cnt != s0 + 1) begin errors++; $display("FAIL fg_strobe got %0d want 1", strobe_cnt - s0); end
    checks++; if (fg_color !== 6'h3f) begin errors++; $display("FAIL fg_no_commit got %h want 3f", fg_color); end
    send_bits(8'hc0, 7, rx);
    last_bit(1'b0, 1'b0, strb, mp3, fp3);
    cs_high();
    checks++; if (strb !== 4'b0100) begin errors++; $display("FAIL strobe_timing got %b want 0100", strb); end
    checks++; if (fp3 !== 6'h3f) begin errors++; $display("FAIL fg_during_strobe got %h want 3f", fp3); end
    checks++; if (fg_color !== 6'h15) begin errors++; $display("FAIL fg_after_commit got %h want 15", fg_color); end
    checks++; if (mode_sel !== 2'b10) begin errors++; $display("FAIL fg_mode_hold got %b want 10", mode_sel); end
  endtask

  task automatic test_partial();
    int s0;
    logic [7:0] rx;
    s0 = strobe_cnt;
    cs_low();
    send_bits(8'h81, 5, rx);
    cs_high();
    checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL partial_strobe got %0d want 0", strobe_cnt - s0); end
    cs_low();
    send_bits(8'h81, 8, rx);
    cs_high();
    checks++; if (strobe_cnt != s0 + 1) begin errors++; $display("FAIL full_strobe got %0d want 1", strobe_cnt - s0); end
    checks++; if (bg_color !== 6'h00) begin errors++; $display("FAIL bg_pre_commit got %h want 00", bg_color); end
    pulse_frame();
    checks++; if (bg_color !== 6'h01) begin errors++; $display("FAIL bg_post_commit got %h want 01", bg_color); end
    checks++; if (fg_color !== 6'h15) begin errors++; $display("FAIL bg_fg_hold got %h want 15", fg_color); end
  endtask

  task automatic test_bypass();
    logic [7:0] rx;
    logic [3:0] strb;
    logic [1:0] mp3;
    logic [5:0] fp3;
    cs_low();
    send_bits(8'h03, 7, rx);
    last_bit(1'b1, 1'b1, strb, mp3, fp3);
    checks++; if (strb !== 4'b0100) begin errors++; $display("FAIL bypass_strobe got %b want 0100", strb); end
    checks++; if (mp3 !== 2'b10) begin errors++; $display("FAIL bypass_mode_before got %b want 10", mp3); end
    checks++; if (mode_sel !== 2'b11) begin errors++; $display("FAIL bypass_mode got %b want 11", mode_sel); end
    cs_high();
    checks++; if (mode_sel !== 2'b11) begin errors++; $display("FAIL bypass_mode_hold got %b want 11", mode_sel); end
  endtask

  task automatic test_reset_mid_byte();
    int s0;
    logic [7:0] rx;
    cs_low();
    send_bits(8'h01, 4, rx);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (mode_sel !== 2'b00) begin errors++; $display("FAIL midrst_mode got %b want 00", mode_sel); end
    checks++; if (fg_color !== 6'h3f) begin errors++; $display("FAIL midrst_fg got %h want 3f", fg_color); end
    checks++; if (bg_color !== 6'h00) begin errors++; $display("FAIL midrst_bg got %h want 00", bg_color); end
    s0 = strobe_cnt;
    cs_low();
    send_bits(8'h01, 8, rx);
    send_bits(8'hc0, 8, rx);
    cs_high();
    checks++; if (strobe_cnt != s0 + 2) begin errors++; $display("FAIL midrst_strobes got %0d want 2", strobe_cnt - s0); end
    checks++; if (mode_sel !== 2'b01) begin errors++; $display("FAIL midrst_mode_after got %b want 01", mode_sel); end
    checks++; if (fg_color !== 6'h3f) begin errors++; $display("FAIL midrst_fg_after got %h want 3f", fg_color); end
  endtask

  task automatic test_miso();
    logic [7:0] rx;
    cs_low();
    send_bits(8'h5a, 8, rx);
    cs_high();
    cs_low();
    send_bits(8'h00, 8, rx);
    cs_high();
`ifdef SPI_MISO_READBACK_EN
    checks++; if (rx !== 8'h5a) begin errors++; $display("FAIL miso_readback got %h want 5a", rx); end
`else
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL miso_tied got %h want 00", rx); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL miso_idle got %b want 0", spi_miso); end
`endif
  endtask

  initial begin
    test_reset();
    test_mode_write();
    test_fg_commit();
    test_partial();
    test_bypass();
    test_reset_mid_byte();
    test_miso();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
